// File: rtl/noc_pkg.sv
// Shared constants and the packet type for the NoC input buffer slice.
package noc_pkg;

    localparam int DATA_PACKET_SIZE_DEFAULT = 32;
    localparam int BUF_DEPTH_DEFAULT        = 4;

    typedef logic [DATA_PACKET_SIZE_DEFAULT-1:0] noc_packet_t;

endpackage : noc_pkg

// File: rtl/noc_input_buffer_if.sv
// Point-to-point valid/ready link carrying one packet per transfer.
// Valid/ready: a packet moves on a rising edge where valid && ready are both 1;
// once valid is raised it stays high, with data stable, until that edge.
interface bus #(
    parameter int DATA_PACKET_SIZE = noc_pkg::DATA_PACKET_SIZE_DEFAULT
);

    logic                        valid;
    logic                        ready;
    logic [DATA_PACKET_SIZE-1:0] data;

    modport source (output valid, output data, input  ready);
    modport sink   (input  valid, input  data, output ready);

endinterface : bus

// File: rtl/noc_buf_mem.sv
// Packet storage array: one synchronous write port, one asynchronous read port.
// Contents are never reset; the pointers alone decide what is live.
module noc_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : noc_buf_mem

// File: rtl/noc_input_buffer.sv
// Elastic FIFO stage in front of a router port: in-order, unmodified packet relay.
// Optional NOC_BUF_BYPASS_EN forwards a packet combinationally when the buffer is empty.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int DATA_PACKET_SIZE = DATA_PACKET_SIZE_DEFAULT,
    parameter int DEPTH            = BUF_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus.sink                       in_bus,
    bus.source                     out_bus,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q,  count_d;
    logic                        full, empty;
    logic                        bypass;
    logic                        push, pop;
    logic [DATA_PACKET_SIZE-1:0] rd_data;

    noc_buf_mem #(
        .WIDTH (DATA_PACKET_SIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_bus.data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign occupancy = count_q;

    // Handshake outputs; in_bus.ready depends only on registered state and reset.
    always_comb begin
        bypass        = 1'b0;
        in_bus.ready  = rst_n && !full;
`ifdef NOC_BUF_BYPASS_EN
        bypass        = rst_n && empty && in_bus.valid;
`endif
        out_bus.valid = !empty || bypass;
        out_bus.data  = '0;
        if (bypass) begin
            out_bus.data = in_bus.data;
        end else if (!empty) begin
            out_bus.data = rd_data;
        end
        // A bypassed packet that is accepted downstream is never stored.
        push = in_bus.valid && in_bus.ready && !(bypass && out_bus.ready);
        pop  = !empty && out_bus.ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : noc_input_buffer
